// File: rtl/cavlc_scan_ctrl_if.sv
// +-----------------------------------------------------------------------+
// | cavlc_scan_ctrl_if : handshake, buffer and statistics bus of the scan  |
// | sequencer.                                            Revision: 1.0   |
// +-----------------------------------------------------------------------+
`default_nettype none

interface cavlc_scan_ctrl_if #(
  parameter int COEFF_W   = 8,
  parameter int NUM_COEFF = 16
);
  localparam int AW = (NUM_COEFF > 1) ? $clog2(NUM_COEFF) : 1;

  logic               start_i;
  logic               abort_i;
  logic               busy_o;
  logic               rd_en_o;
  logic [AW-1:0]      rd_addr_o;
  logic [COEFF_W-1:0] rd_data_i;
  logic               cnt_rst_o;
  logic               start_cnt_o;
  logic [COEFF_W-1:0] coeff_o;
  logic [4:0]         total_coeff_o;
  logic [1:0]         trailing_ones_o;
  logic [3:0]         total_zeros_o;
  logic               stat_valid_o;
  logic               stat_ready_i;

  // Sequencer side
  modport slave (
    input  start_i, abort_i, rd_data_i, stat_ready_i,
    output busy_o, rd_en_o, rd_addr_o, cnt_rst_o, start_cnt_o, coeff_o,
           total_coeff_o, trailing_ones_o, total_zeros_o, stat_valid_o
  );

  // Requester / buffer / consumer side
  modport master (
    output start_i, abort_i, rd_data_i, stat_ready_i,
    input  busy_o, rd_en_o, rd_addr_o, cnt_rst_o, start_cnt_o, coeff_o,
           total_coeff_o, trailing_ones_o, total_zeros_o, stat_valid_o
  );
endinterface

`default_nettype wire

// File: rtl/cavlc_scan_ctrl.sv
// +-----------------------------------------------------------------------+
// | cavlc_scan_ctrl : reverse-zigzag scan of one residual block, feeding   |
// | the run-before counter and collecting coeff_token/total_zeros stats.   |
// |                                                       Revision: 1.0   |
// +-----------------------------------------------------------------------+
`default_nettype none

module cavlc_scan_ctrl #(
  parameter int COEFF_W   = 8,
  parameter int NUM_COEFF = 16
) (
  input  wire logic        clk,
  input  wire logic        rst,
  cavlc_scan_ctrl_if.slave bus
);
  localparam int            AW     = (NUM_COEFF > 1) ? $clog2(NUM_COEFF) : 1;
  localparam logic [AW-1:0] C_LAST = AW'(NUM_COEFF - 1);
  localparam logic [COEFF_W-1:0] C_PLUS1  = COEFF_W'(1);
  localparam logic [COEFF_W-1:0] C_MINUS1 = {COEFF_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLR   = 3'd1,
    S_FETCH = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [AW-1:0] r_addr;
  logic [4:0]    r_tc;
  logic [1:0]    r_t1;
  logic [3:0]    r_tz;
  logic          r_seen_nz;
  logic          r_t1_open;
  logic          r_abort_clr;

  logic          w_abort;
  logic          w_feed;
  logic          w_nz;
  logic          w_pm1;

  assign w_abort = bus.abort_i && (r_state != S_IDLE);
  assign w_feed  = (r_state == S_FETCH) || (r_state == S_DRAIN);
  assign w_nz    = (bus.rd_data_i != '0);
  assign w_pm1   = (bus.rd_data_i == C_PLUS1) || (bus.rd_data_i == C_MINUS1);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start_i) w_next = S_CLR;
      S_CLR:   w_next = (r_addr == '0) ? S_DRAIN : S_FETCH;
      S_FETCH: if (r_addr == '0) w_next = S_DRAIN;
      S_DRAIN: w_next = S_DONE;
      S_DONE:  if (bus.stat_ready_i) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (w_abort) w_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_tc        <= '0;
      r_t1        <= '0;
      r_tz        <= '0;
      r_seen_nz   <= 1'b0;
      r_t1_open   <= 1'b0;
      r_abort_clr <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_abort_clr <= w_abort;
      if (w_abort) begin
        r_addr    <= '0;
        r_tc      <= '0;
        r_t1      <= '0;
        r_tz      <= '0;
        r_seen_nz <= 1'b0;
        r_t1_open <= 1'b0;
      end else begin
        if (r_state == S_IDLE && bus.start_i) r_addr <= C_LAST;
        if (r_state == S_CLR || r_state == S_FETCH) r_addr <= r_addr - 1'b1;
        if (r_state == S_CLR) begin
          r_tc      <= '0;
          r_t1      <= '0;
          r_tz      <= '0;
          r_seen_nz <= 1'b0;
          r_t1_open <= 1'b1;
        end
        if (w_feed) begin
          if (w_nz) begin
            r_tc      <= r_tc + 5'd1;
            r_seen_nz <= 1'b1;
            // A 4th +/-1 or any larger magnitude closes the trailing-ones run
            if (r_t1_open && w_pm1 && r_t1 != 2'd3) r_t1 <= r_t1 + 2'd1;
            else                                     r_t1_open <= 1'b0;
          end else if (r_seen_nz) begin
            r_tz <= r_tz + 4'd1;
          end
        end
      end
    end
  end

  assign bus.busy_o          = (r_state != S_IDLE);
  assign bus.rd_en_o         = (r_state == S_CLR) || (r_state == S_FETCH);
  assign bus.rd_addr_o       = bus.rd_en_o ? r_addr : '0;
  assign bus.cnt_rst_o       = (r_state == S_CLR) || r_abort_clr;
  assign bus.start_cnt_o     = w_feed;
  assign bus.coeff_o         = w_feed ? bus.rd_data_i : '0;
  assign bus.stat_valid_o    = (r_state == S_DONE);
  assign bus.total_coeff_o   = r_tc;
  assign bus.trailing_ones_o = r_t1;
  assign bus.total_zeros_o   = r_tz;

endmodule

`default_nettype wire

// File: tb/tb_cavlc_scan_ctrl.sv
// +-----------------------------------------------------------------------+
// | tb_cavlc_scan_ctrl : directed bench for the residual block scanner.    |
// |                                                       Revision: 1.0   |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_cavlc_scan_ctrl;
  localparam int C_CW = 8;
  localparam int C_N  = 16;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  logic [C_CW-1:0] mem [C_N];

  cavlc_scan_ctrl_if #(.COEFF_W(C_CW), .NUM_COEFF(C_N)) bus ();

  cavlc_scan_ctrl #(.COEFF_W(C_CW), .NUM_COEFF(C_N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Coefficient buffer: one-cycle read latency
  always @(posedge clk) begin
    if (bus.rd_en_o) bus.rd_data_i <= mem[bus.rd_addr_o];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < C_N; i++) mem[i] = 8'h00;
  endtask

  // Full scan with per-cycle trace checks; ends one cycle after handshake
  task automatic run_block(input int tc, input int t1, input int tz);
    bus.stat_ready_i = 1'b1;
    bus.start_i      = 1'b1;
    step();
    bus.start_i = 1'b0;
    for (int k = 1; k <= C_N + 1; k++) begin
      chk("busy", bus.busy_o, 1);
      chk("rd_en", bus.rd_en_o, (k <= C_N) ? 1 : 0);
      if (k <= C_N) chk("rd_addr", bus.rd_addr_o, C_N - k);
      chk("cnt_rst", bus.cnt_rst_o, (k == 1) ? 1 : 0);
      chk("start_cnt", bus.start_cnt_o, (k >= 2) ? 1 : 0);
      chk("coeff", bus.coeff_o, (k >= 2) ? mem[C_N + 1 - k] : 8'h00);
      chk("valid_early", bus.stat_valid_o, 0);
      step();
    end
    chk("valid", bus.stat_valid_o, 1);
    chk("total_coeff", bus.total_coeff_o, tc);
    chk("trailing_ones", bus.trailing_ones_o, t1);
    chk("total_zeros", bus.total_zeros_o, tz);
    step();
    chk("idle_busy", bus.busy_o, 0);
    chk("idle_valid", bus.stat_valid_o, 0);
    chk("held_tc", bus.total_coeff_o, tc);
  endtask

  task automatic load_t1();
    clear_mem();
    mem[1] = 8'd3;
    mem[2] = 8'hFF;
    mem[5] = 8'hFF;
    mem[6] = 8'd1;
    mem[8] = 8'd1;
  endtask

  initial begin
    n_tests          = 0;
    n_fail           = 0;
    rst              = 1'b0;
    bus.start_i      = 1'b0;
    bus.abort_i      = 1'b0;
    bus.stat_ready_i = 1'b0;
    bus.rd_data_i    = '0;
    clear_mem();
    step();
    step();
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_rd_en", bus.rd_en_o, 0);
    chk("rst_cnt_rst", bus.cnt_rst_o, 0);
    chk("rst_valid", bus.stat_valid_o, 0);
    chk("rst_tc", bus.total_coeff_o, 0);
    rst = 1'b1;
    step();

    // Mixed block: 0,3,-1,0,0,-1,1,0,1 then zeros
    load_t1();
    run_block(5, 3, 4);

    // All-zero block
    clear_mem();
    run_block(0, 0, 0);

    // All ones
    for (int i = 0; i < C_N; i++) mem[i] = 8'd1;
    run_block(16, 3, 0);

    // 5,1,1 then zeros
    clear_mem();
    mem[0] = 8'd5; mem[1] = 8'd1; mem[2] = 8'd1;
    run_block(3, 2, 0);

    // 2 at idx0, -1 at idx15
    clear_mem();
    mem[0] = 8'd2; mem[15] = 8'hFF;
    run_block(2, 1, 14);

    // Back-pressure in DONE with start pulses
    clear_mem();
    mem[0] = 8'd5; mem[1] = 8'd1; mem[2] = 8'd1;
    bus.stat_ready_i = 1'b0;
    bus.start_i      = 1'b1;
    step();
    bus.start_i = 1'b0;
    for (int k = 1; k <= C_N + 1; k++) step();
    for (int j = 0; j < 5; j++) begin
      chk("bp_valid", bus.stat_valid_o, 1);
      chk("bp_busy", bus.busy_o, 1);
      chk("bp_tc", bus.total_coeff_o, 3);
      chk("bp_t1", bus.trailing_ones_o, 2);
      chk("bp_tz", bus.total_zeros_o, 0);
      bus.start_i = (j % 2 == 0);
      step();
    end
    bus.start_i      = 1'b0;
    bus.stat_ready_i = 1'b1;
    chk("bp_valid_last", bus.stat_valid_o, 1);
    step();
    chk("bp_idle", bus.busy_o, 0);
    step();
    chk("bp_no_queue", bus.busy_o, 0);

    // Abort on cycle 7
    for (int i = 0; i < C_N; i++) mem[i] = 8'd1;
    bus.start_i = 1'b1;
    step();
    bus.start_i = 1'b0;
    for (int k = 1; k < 7; k++) step();
    chk("ab_pre_tc", bus.total_coeff_o, 5);
    bus.abort_i = 1'b1;
    step();
    bus.abort_i = 1'b0;
    chk("ab_busy", bus.busy_o, 0);
    chk("ab_cnt_rst", bus.cnt_rst_o, 1);
    chk("ab_rd_en", bus.rd_en_o, 0);
    chk("ab_start_cnt", bus.start_cnt_o, 0);
    chk("ab_valid", bus.stat_valid_o, 0);
    chk("ab_tc", bus.total_coeff_o, 0);
    chk("ab_t1", bus.trailing_ones_o, 0);
    step();
    chk("ab_cnt_rst_done", bus.cnt_rst_o, 0);
    load_t1();
    run_block(5, 3, 4);

    // Asynchronous reset mid-FETCH
    for (int i = 0; i < C_N; i++) mem[i] = 8'd1;
    bus.start_i = 1'b1;
    step();
    bus.start_i = 1'b0;
    for (int k = 1; k < 5; k++) step();
    chk("ar_pre_busy", bus.busy_o, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_busy", bus.busy_o, 0);
    chk("ar_rd_en", bus.rd_en_o, 0);
    chk("ar_start_cnt", bus.start_cnt_o, 0);
    chk("ar_cnt_rst", bus.cnt_rst_o, 0);
    chk("ar_tc", bus.total_coeff_o, 0);
    step();
    rst = 1'b1;
    step();
    clear_mem();
    mem[0] = 8'd2; mem[15] = 8'hFF;
    run_block(2, 1, 14);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
